pc_sequencer: RTL and testbench

- Parametrised program-counter block for the single-cycle RISC-V core; it replaces the bare PCNext register.
- Holds the PC and generates the sequential PC+4 step internally.
- Accepts branch/jump redirects, stall and halt/resume control, traps on misaligned targets, and counts fetches.
- Sits between the next-PC control logic and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter block for the single-cycle RISC-V core. It holds the
// current fetch address and produces the sequential step internally. It also
// applies branch/jump redirects, handles stall and halt/resume, traps on
// misaligned redirect targets and counts accepted fetches.
//
// Optional feature (compile-time macro PC_SEQUENCER_RVC_EN):
//   When defined, the block adds a Compressed input. In RUN the sequential
//   step becomes +2 when Compressed=1, and redirect targets only need 2-byte
//   alignment. PCPlus4 stays +4 in both builds.
//
// Parameters:
//   XLEN         width of PC, redirect targets and the sequential adder
//   RESET_VECTOR PC loaded on reset (truncated/zero-extended to XLEN)
//   CNT_W        width of FetchCount
//
// Ports:
//   CLK            rising-edge clock
//   RST            synchronous reset, active-high, overrides everything
//   Stall          hold PC this cycle (RUN only)
//   Redirect       load RedirectTarget this cycle (RUN or HALTED)
//   RedirectTarget branch/jump target
//   Halt           enter HALTED (RUN only)
//   Resume         leave HALTED
//   Compressed     (RVC build only) current instruction is 16-bit
//   PC             current fetch address (registered)
//   PCPlus4        PC+4 modulo 2^XLEN (combinational)
//   PCValid        PC is a valid fetch address (state decode, RUN only)
//   Misaligned     sticky trap flag, cleared only by RST
//   FetchCount     number of accepted fetches, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [XLEN-1:0]  RedirectTarget,
  input  logic             Halt,
  input  logic             Resume,
`ifdef PC_SEQUENCER_RVC_EN
  input  logic             Compressed,
`endif
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PCPlus4,
  output logic             PCValid,
  output logic             Misaligned,
  output logic [CNT_W-1:0] FetchCount
);

  localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VECTOR);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    TRAP   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [XLEN-1:0]  pc, pc_n;
  logic             mis, mis_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [XLEN-1:0]  seq_step;
  logic             target_bad;

  // Sequential step size and alignment requirement depend on whether
  // compressed instructions are supported.
  always_comb begin
`ifdef PC_SEQUENCER_RVC_EN
    seq_step   = Compressed ? XLEN'(2) : XLEN'(4);
    target_bad = RedirectTarget[0];
`else
    seq_step   = XLEN'(4);
    target_bad = |RedirectTarget[1:0];
`endif
  end

  // State register; reset wins over every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= BOOT;
      pc    <= RESET_PC;
      mis   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      mis   <= mis_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic. In RUN exactly one of redirect / halt / stall / step
  // is taken, in that priority order.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    mis_n   = mis;
    cnt_n   = cnt;

    case (state)
      BOOT: begin
        state_n = RUN;
      end

      RUN: begin
        // The current PC is consumed on any non-stalled RUN cycle, even when
        // that cycle also redirects or halts.
        if (!Stall) begin
          cnt_n = cnt + CNT_W'(1);
        end

        if (Redirect) begin
          if (target_bad) begin
            state_n = TRAP;
            mis_n   = 1'b1;
          end else begin
            pc_n = RedirectTarget;
          end
        end else if (Halt) begin
          state_n = HALTED;
        end else if (!Stall) begin
          pc_n = pc + seq_step;
        end
      end

      HALTED: begin
        // A redirect takes precedence over Resume and keeps the block halted.
        if (Redirect) begin
          if (target_bad) begin
            state_n = TRAP;
            mis_n   = 1'b1;
          end else begin
            pc_n = RedirectTarget;
          end
        end else if (Resume) begin
          state_n = RUN;
        end
      end

      TRAP: begin
        mis_n = 1'b1;
      end

      default: begin
        state_n = BOOT;
      end
    endcase
  end

  assign PC         = pc;
  assign PCPlus4    = pc + XLEN'(4);
  assign PCValid    = (state == RUN);
  assign Misaligned = mis;
  assign FetchCount = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        Halt;
  logic        Resume;
`ifdef PC_SEQUENCER_RVC_EN
  logic        Compressed;
`endif
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCValid;
  logic        Misaligned;
  logic [31:0] FetchCount;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_1000),
    .CNT_W(32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Stall(Stall),
    .Redirect(Redirect),
    .RedirectTarget(RedirectTarget),
    .Halt(Halt),
    .Resume(Resume),
`ifdef PC_SEQUENCER_RVC_EN
    .Compressed(Compressed),
`endif
    .PC(PC),
    .PCPlus4(PCPlus4),
    .PCValid(PCValid),
    .Misaligned(Misaligned),
    .FetchCount(FetchCount)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 0; Redirect = 0; RedirectTarget = '0; Halt = 0; Resume = 0;
`ifdef PC_SEQUENCER_RVC_EN
    Compressed = 0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    tick(); tick();
    checks++; if (PC !== 32'h1000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h1000); end
    checks++; if (PCValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", PCValid); end
    checks++; if (Misaligned !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", Misaligned); end
    checks++; if (FetchCount !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", FetchCount); end
    checks++; if (PCPlus4 !== 32'h1004) begin failures++; $display("FAIL reset_plus4 got=%h exp=%h", PCPlus4, 32'h1004); end
    RST = 0;
    #1;
    checks++; if (PCValid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", PCValid); end
    tick();
    checks++; if (PCValid !== 1'b1) begin failures++; $display("FAIL run_valid got=%b exp=1", PCValid); end
    checks++; if (PC !== 32'h1000) begin failures++; $display("FAIL first_fetch got=%h exp=%h", PC, 32'h1000); end
    checks++; if (FetchCount !== 32'd0) begin failures++; $display("FAIL first_cnt got=%0d exp=0", FetchCount); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (PC !== 32'h1000 + 32'(4 * i)) begin failures++; $display("FAIL step_pc[%0d] got=%h exp=%h", i, PC, 32'h1000 + 32'(4 * i)); end
      checks++; if (FetchCount !== 32'(i)) begin failures++; $display("FAIL step_cnt[%0d] got=%0d exp=%0d", i, FetchCount, i); end
    end
  endtask

  task automatic test_stall();
    Redirect = 1; RedirectTarget = 32'h100;
    tick();
    checks++; if (PC !== 32'h100) begin failures++; $display("FAIL stall_redir_pc got=%h exp=%h", PC, 32'h100); end
    checks++; if (FetchCount !== 32'd4) begin failures++; $display("FAIL stall_redir_cnt got=%0d exp=4", FetchCount); end
    Redirect = 0; Stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (PC !== 32'h100) begin failures++; $display("FAIL stall_hold_pc[%0d] got=%h exp=%h", i, PC, 32'h100); end
      checks++; if (FetchCount !== 32'd4) begin failures++; $display("FAIL stall_hold_cnt[%0d] got=%0d exp=4", i, FetchCount); end
    end
    Stall = 0;
    tick();
    checks++; if (PC !== 32'h104) begin failures++; $display("FAIL stall_release_pc got=%h exp=%h", PC, 32'h104); end
    checks++; if (FetchCount !== 32'd5) begin failures++; $display("FAIL stall_release_cnt got=%0d exp=5", FetchCount); end
  endtask

  task automatic test_redirect_priority();
    Redirect = 1; RedirectTarget = 32'h2000; Halt = 1; Stall = 1;
    tick();
    checks++; if (PC !== 32'h2000) begin failures++; $display("FAIL prio_pc got=%h exp=%h", PC, 32'h2000); end
    checks++; if (PCValid !== 1'b1) begin failures++; $display("FAIL prio_valid got=%b exp=1", PCValid); end
    checks++; if (FetchCount !== 32'd5) begin failures++; $display("FAIL prio_cnt got=%0d exp=5", FetchCount); end
    Redirect = 0; Stall = 0; Halt = 1;
    tick();
    checks++; if (PCValid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%b exp=0", PCValid); end
    checks++; if (PC !== 32'h2000) begin failures++; $display("FAIL halt_pc got=%h exp=%h", PC, 32'h2000); end
    checks++; if (FetchCount !== 32'd6) begin failures++; $display("FAIL halt_cnt got=%0d exp=6", FetchCount); end
    Halt = 0; Resume = 1;
    tick();
    checks++; if (PCValid !== 1'b1) begin failures++; $display("FAIL resume_valid got=%b exp=1", PCValid); end
    checks++; if (FetchCount !== 32'd6) begin failures++; $display("FAIL resume_cnt got=%0d exp=6", FetchCount); end
    Resume = 0;
    tick();
    checks++; if (PC !== 32'h2004) begin failures++; $display("FAIL resume_step got=%h exp=%h", PC, 32'h2004); end
    checks++; if (PCPlus4 !== 32'h2008) begin failures++; $display("FAIL resume_plus4 got=%h exp=%h", PCPlus4, 32'h2008); end
  endtask

  task automatic test_halted_redirect();
    Halt = 1;
    tick();
    Halt = 0; Redirect = 1; RedirectTarget = 32'h3000; Resume = 1;
    tick();
    checks++; if (PC !== 32'h3000) begin failures++; $display("FAIL hredir_pc got=%h exp=%h", PC, 32'h3000); end
    checks++; if (PCValid !== 1'b0) begin failures++; $display("FAIL hredir_valid got=%b exp=0", PCValid); end
    Redirect = 0; Resume = 0; Halt = 1;
    tick();
    checks++; if (PCValid !== 1'b0) begin failures++; $display("FAIL hhalt_valid got=%b exp=0", PCValid); end
    checks++; if (FetchCount !== 32'd8) begin failures++; $display("FAIL hfrozen_cnt got=%0d exp=8", FetchCount); end
    Halt = 0; Resume = 1;
    tick();
    Resume = 0;
    tick();
    checks++; if (PC !== 32'h3004) begin failures++; $display("FAIL hresume_pc got=%h exp=%h", PC, 32'h3004); end
    checks++; if (FetchCount !== 32'd9) begin failures++; $display("FAIL hresume_cnt got=%0d exp=9", FetchCount); end
  endtask

  task automatic test_trap();
    Redirect = 1; RedirectTarget = 32'h2002;
    tick();
    checks++; if (Misaligned !== 1'b1) begin failures++; $display("FAIL trap_mis got=%b exp=1", Misaligned); end
    checks++; if (PCValid !== 1'b0) begin failures++; $display("FAIL trap_valid got=%b exp=0", PCValid); end
    checks++; if (PC !== 32'h3004) begin failures++; $display("FAIL trap_pc got=%h exp=%h", PC, 32'h3004); end
    checks++; if (FetchCount !== 32'd10) begin failures++; $display("FAIL trap_cnt got=%0d exp=10", FetchCount); end
    Resume = 1; Halt = 1; RedirectTarget = 32'h4000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (PC !== 32'h3004 || PCValid !== 1'b0 || Misaligned !== 1'b1 || FetchCount !== 32'd10) begin
        failures++; $display("FAIL trap_hold[%0d] got pc=%h v=%b m=%b c=%0d exp pc=%h v=0 m=1 c=10", i, PC, PCValid, Misaligned, FetchCount, 32'h3004);
      end
    end
    RST = 1;
    tick();
    checks++; if (Misaligned !== 1'b0) begin failures++; $display("FAIL trap_rst_mis got=%b exp=0", Misaligned); end
    checks++; if (PC !== 32'h1000) begin failures++; $display("FAIL trap_rst_pc got=%h exp=%h", PC, 32'h1000); end
    checks++; if (FetchCount !== 32'd0) begin failures++; $display("FAIL trap_rst_cnt got=%0d exp=0", FetchCount); end
    RST = 0; idle_inputs();
    tick();
    checks++; if (PCValid !== 1'b1) begin failures++; $display("FAIL trap_rerun_valid got=%b exp=1", PCValid); end
  endtask

  task automatic test_halted_trap();
    Halt = 1;
    tick();
    Halt = 0; Redirect = 1; RedirectTarget = 32'h5001;
    tick();
    checks++; if (Misaligned !== 1'b1) begin failures++; $display("FAIL htrap_mis got=%b exp=1", Misaligned); end
    checks++; if (PC !== 32'h1000) begin failures++; $display("FAIL htrap_pc got=%h exp=%h", PC, 32'h1000); end
    Redirect = 0; Resume = 1;
    tick();
    checks++; if (PCValid !== 1'b0) begin failures++; $display("FAIL htrap_stuck got=%b exp=0", PCValid); end
    idle_inputs();
    RST = 1;
    tick();
    RST = 0;
    tick();
  endtask

  task automatic test_wrap();
    Redirect = 1; RedirectTarget = 32'hFFFF_FFF8;
    tick();
    checks++; if (PC !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap0_pc got=%h exp=%h", PC, 32'hFFFF_FFF8); end
    checks++; if (PCPlus4 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap0_plus4 got=%h exp=%h", PCPlus4, 32'hFFFF_FFFC); end
    Redirect = 0;
    tick();
    checks++; if (PC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap1_pc got=%h exp=%h", PC, 32'hFFFF_FFFC); end
    checks++; if (PCPlus4 !== 32'h0) begin failures++; $display("FAIL wrap1_plus4 got=%h exp=0", PCPlus4); end
    tick();
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL wrap2_pc got=%h exp=0", PC); end
    checks++; if (PCPlus4 !== 32'h4) begin failures++; $display("FAIL wrap2_plus4 got=%h exp=4", PCPlus4); end
    checks++; if (Misaligned !== 1'b0) begin failures++; $display("FAIL wrap_mis got=%b exp=0", Misaligned); end
    checks++; if (FetchCount !== 32'd3) begin failures++; $display("FAIL wrap_cnt got=%0d exp=3", FetchCount); end
  endtask

`ifdef PC_SEQUENCER_RVC_EN
  task automatic test_rvc();
    Redirect = 1; RedirectTarget = 32'h40;
    tick();
    Redirect = 0; Compressed = 1;
    tick();
    checks++; if (PC !== 32'h42) begin failures++; $display("FAIL rvc_step got=%h exp=%h", PC, 32'h42); end
    checks++; if (PCPlus4 !== 32'h46) begin failures++; $display("FAIL rvc_plus4 got=%h exp=%h", PCPlus4, 32'h46); end
    Compressed = 0; Redirect = 1; RedirectTarget = 32'h46;
    tick();
    checks++; if (PC !== 32'h46 || Misaligned !== 1'b0) begin failures++; $display("FAIL rvc_redir46 got pc=%h m=%b exp pc=46 m=0", PC, Misaligned); end
    RedirectTarget = 32'h47;
    tick();
    checks++; if (Misaligned !== 1'b1 || PC !== 32'h46) begin failures++; $display("FAIL rvc_redir47 got pc=%h m=%b exp pc=46 m=1", PC, Misaligned); end
    idle_inputs();
    RST = 1;
    tick();
    RST = 0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1;
    idle_inputs();
    test_reset();
    test_stall();
    test_redirect_priority();
    test_halted_redirect();
    test_trap();
    test_halted_trap();
    test_wrap();
`ifdef PC_SEQUENCER_RVC_EN
    test_rvc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
